// File: rtl/traceback_walker.sv
// Walks a LENGTH x LENGTH direction grid from the bottom-right cell back to the
// origin, streaming one (x, y, op) alignment record per cell over valid/ready.
module traceback_walker #(
    parameter int unsigned LENGTH      = 10,
    parameter int unsigned CORD_LENGTH = 8,
    parameter int unsigned ADDR_SIZE   = 9,
    parameter logic [1:0]  TOP_DIR     = 2'b00,
    parameter logic [1:0]  LEFT_DIR    = 2'b01,
    parameter logic [1:0]  CORNER_DIR  = 2'b10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   dir_ren,
    output logic [ADDR_SIZE-1:0]   dir_addr,
    input  logic [1:0]             dir_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CORD_LENGTH-1:0] out_x,
    output logic [CORD_LENGTH-1:0] out_y,
    output logic [1:0]             out_op,
    output logic                   out_last,
    output logic                   done,
    output logic                   err,
    output logic [CORD_LENGTH:0]   step_count
);

    localparam int unsigned CW     = CORD_LENGTH;
    localparam int unsigned STEP_W = CORD_LENGTH + 1;
    localparam int unsigned AW     = ADDR_SIZE;
    localparam logic [1:0]  ILLEGAL_DIR = 2'b11;
    localparam logic [CORD_LENGTH-1:0] START_CORD = CW'(LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       x_q, x_d;
    logic [CW-1:0]       y_q, y_d;
    logic [1:0]          op_q, op_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                ren_q, ren_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                xfer;

    // Row-major address of a grid cell.
    function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] cx,
                                                input logic [CW-1:0] cy);
        cell_addr = AW'(cy) * AW'(LENGTH) + AW'(cx);
    endfunction

    // True when applying op at (cx, cy) would step outside the grid.
    function automatic logic exits_grid(input logic [CW-1:0] cx,
                                        input logic [CW-1:0] cy,
                                        input logic [1:0]    op);
        exits_grid = ((cx == '0) && ((op == LEFT_DIR) || (op == CORNER_DIR))) ||
                     ((cy == '0) && ((op == TOP_DIR)  || (op == CORNER_DIR)));
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        last_d  = last_q;
        step_d  = step_q;
        err_d   = err_q;
        xfer    = valid_q && out_ready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = START_CORD;
                    y_d     = START_CORD;
                    step_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dir_rdata == ILLEGAL_DIR) begin
                    state_d = ST_ERR;
                end else begin
                    op_d    = dir_rdata;
                    last_d  = exits_grid(x_q, y_q, dir_rdata);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    step_d = step_q + STEP_W'(1);
                    last_d = 1'b0;
                    if (last_q) begin
                        // Exiting move: coordinates are left untouched.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        if ((op_q == LEFT_DIR) || (op_q == CORNER_DIR)) begin
                            x_d = x_q - CW'(1);
                        end
                        if ((op_q == TOP_DIR) || (op_q == CORNER_DIR)) begin
                            y_d = y_q - CW'(1);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end

        // Registered outputs are derived from the state being entered.
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                  (state_d == ST_EMIT)  || (state_d == ST_ERR);
        ren_d   = (state_d == ST_FETCH);
        addr_d  = (state_d == ST_FETCH) ? cell_addr(x_d, y_d) : addr_q;
        valid_d = (state_d == ST_EMIT);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ren_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ren_q   <= ren_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            step_q  <= step_d;
        end
    end

    assign busy       = busy_q;
    assign dir_ren    = ren_q;
    assign dir_addr   = addr_q;
    assign out_valid  = valid_q;
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_op     = op_q;
    assign out_last   = last_q;
    assign done       = done_q;
    assign err        = err_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_traceback_walker.sv
// Directed bench for traceback_walker on a 4x4 grid with a behavioural
// one-cycle-latency direction memory.
module tb_traceback_walker;

    localparam int unsigned LEN = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned AW  = 9;
    localparam logic [1:0] T   = 2'b00;
    localparam logic [1:0] L   = 2'b01;
    localparam logic [1:0] C   = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    dir_rdata = 2'b00;
    logic          busy, dir_ren, out_valid, out_last, done, err;
    logic [AW-1:0] dir_addr;
    logic [CW-1:0] out_x, out_y;
    logic [1:0]    out_op;
    logic [CW:0]   step_count;

    int checks = 0;
    int failures = 0;
    logic [31:0]   grid = '0;
    logic [AW-1:0] reads[$];

    typedef struct {
        string       name;
        logic [31:0] grid;
        int          nrec;
        logic [55:0] ex;
        logic [55:0] ey;
        logic [13:0] eop;
        bit          mid_start;
    } vec_t;

    vec_t vecs[6];

    traceback_walker #(.LENGTH(LEN), .CORD_LENGTH(CW), .ADDR_SIZE(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .dir_ren(dir_ren), .dir_addr(dir_addr), .dir_rdata(dir_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_op(out_op), .out_last(out_last), .done(done), .err(err),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Direction memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (dir_ren) begin
            dir_rdata <= grid[2*int'(dir_addr) +: 2];
            reads.push_back(dir_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] setc(input logic [31:0] g, input int x, input int y,
                                         input logic [1:0] d);
        logic [31:0] r;
        r = g;
        r[2*(y*LEN+x) +: 2] = d;
        return r;
    endfunction

    task automatic add_rec(inout vec_t v, input int x, input int y, input logic [1:0] op);
        v.ex[8*v.nrec +: 8]  = 8'(x);
        v.ey[8*v.nrec +: 8]  = 8'(y);
        v.eop[2*v.nrec +: 2] = op;
        v.nrec++;
    endtask

    task automatic init_vec(output vec_t v, input string name, input logic [31:0] g,
                            input bit mid);
        v.name = name;
        v.grid = g;
        v.nrec = 0;
        v.ex = '0;
        v.ey = '0;
        v.eop = '0;
        v.mid_start = mid;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run one full traceback with out_ready held high and check every record.
    task automatic run_path(input vec_t v);
        int waits;
        int ax, ay;
        grid = v.grid;
        reads.delete();
        out_ready = 1'b1;
        pulse_start();
        check({v.name, " err_clear"}, 64'(err), 64'(0));
        for (int i = 0; i < v.nrec; i++) begin
            waits = 1;
            if (i > 0) begin
                @(negedge clk);
                start = 1'b0;
            end
            while (!out_valid && waits < 12) begin
                @(negedge clk);
                waits++;
            end
            check({v.name, " latency"}, 64'(waits), 64'(3));
            check({v.name, " valid"}, 64'(out_valid), 64'(1));
            check({v.name, " x"}, 64'(out_x), 64'(v.ex[8*i +: 8]));
            check({v.name, " y"}, 64'(out_y), 64'(v.ey[8*i +: 8]));
            check({v.name, " op"}, 64'(out_op), 64'(v.eop[2*i +: 2]));
            check({v.name, " last"}, 64'(out_last), 64'(i == v.nrec - 1));
            check({v.name, " step_pre"}, 64'(step_count), 64'(i));
            if (v.mid_start && (i == 1 || i == 3)) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({v.name, " done"}, 64'(done), 64'(1));
        check({v.name, " busy_end"}, 64'(busy), 64'(0));
        check({v.name, " steps"}, 64'(step_count), 64'(v.nrec));
        @(negedge clk);
        check({v.name, " done_pulse"}, 64'(done), 64'(0));
        check({v.name, " nreads"}, 64'(reads.size()), 64'(v.nrec));
        for (int i = 0; i < v.nrec && i < reads.size(); i++) begin
            ax = int'(v.ey[8*i +: 8]) * LEN + int'(v.ex[8*i +: 8]);
            check({v.name, " addr"}, 64'(reads[i]), 64'(ax));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " dir_ren"}, 64'(dir_ren), 64'(0));
        check({tag, " dir_addr"}, 64'(dir_addr), 64'(0));
        check({tag, " out_valid"}, 64'(out_valid), 64'(0));
        check({tag, " out_x"}, 64'(out_x), 64'(0));
        check({tag, " out_y"}, 64'(out_y), 64'(0));
        check({tag, " out_op"}, 64'(out_op), 64'(0));
        check({tag, " out_last"}, 64'(out_last), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " err"}, 64'(err), 64'(0));
        check({tag, " step_count"}, 64'(step_count), 64'(0));
    endtask

    initial begin
        logic [31:0] g;
        int waits;
        bit saw_valid, saw_done, saw_busy;

        // corner diagonal
        init_vec(vecs[0], "corner", {16{C}}, 1'b0);
        add_rec(vecs[0], 3, 3, C); add_rec(vecs[0], 2, 2, C);
        add_rec(vecs[0], 1, 1, C); add_rec(vecs[0], 0, 0, C);
        // bottom row all LEFT
        g = {16{C}};
        for (int x = 0; x < 4; x++) g = setc(g, x, 3, L);
        init_vec(vecs[1], "row_left", g, 1'b0);
        add_rec(vecs[1], 3, 3, L); add_rec(vecs[1], 2, 3, L);
        add_rec(vecs[1], 1, 3, L); add_rec(vecs[1], 0, 3, L);
        // all TOP
        init_vec(vecs[2], "top", {16{T}}, 1'b0);
        add_rec(vecs[2], 3, 3, T); add_rec(vecs[2], 3, 2, T);
        add_rec(vecs[2], 3, 1, T); add_rec(vecs[2], 3, 0, T);
        // longest path: left along row 3, then up column 0
        g = {16{T}};
        for (int x = 1; x < 4; x++) g = setc(g, x, 3, L);
        init_vec(vecs[3], "long", g, 1'b0);
        add_rec(vecs[3], 3, 3, L); add_rec(vecs[3], 2, 3, L); add_rec(vecs[3], 1, 3, L);
        add_rec(vecs[3], 0, 3, T); add_rec(vecs[3], 0, 2, T); add_rec(vecs[3], 0, 1, T);
        add_rec(vecs[3], 0, 0, T);
        // same path with start pulses while busy
        vecs[4] = vecs[3];
        vecs[4].name = "long_restart";
        vecs[4].mid_start = 1'b1;
        // corner exiting at x==0 with y>0
        g = {16{C}};
        g = setc(g, 2, 2, L);
        g = setc(g, 1, 2, L);
        init_vec(vecs[5], "corner_exit", g, 1'b0);
        add_rec(vecs[5], 3, 3, C); add_rec(vecs[5], 2, 2, L);
        add_rec(vecs[5], 1, 2, L); add_rec(vecs[5], 0, 2, C);

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        for (int k = 0; k < 6; k++) run_path(vecs[k]);

        // Backpressure on the first record.
        grid = {16{C}};
        reads.delete();
        out_ready = 1'b0;
        pulse_start();
        waits = 1;
        while (!out_valid && waits < 12) begin
            @(negedge clk);
            waits++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp valid", 64'(out_valid), 64'(1));
            check("bp x", 64'(out_x), 64'(3));
            check("bp y", 64'(out_y), 64'(3));
            check("bp op", 64'(out_op), 64'(C));
            check("bp last", 64'(out_last), 64'(0));
            check("bp steps", 64'(step_count), 64'(0));
            check("bp reads", 64'(reads.size()), 64'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp step_after", 64'(step_count), 64'(1));
        check("bp valid_after", 64'(out_valid), 64'(0));
        waits = 0;
        while (!done && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        check("bp done", 64'(done), 64'(1));
        check("bp steps_end", 64'(step_count), 64'(4));
        check("bp reads_end", 64'(reads.size()), 64'(4));
        @(negedge clk);

        // Illegal direction at the first cell.
        grid = setc({16{C}}, 3, 3, BAD);
        reads.delete();
        pulse_start();
        saw_valid = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check("err flag", 64'(err), 64'(1));
        check("err busy", 64'(busy), 64'(0));
        check("err no_valid", 64'(saw_valid), 64'(0));
        check("err no_done", 64'(saw_done), 64'(0));
        check("err steps", 64'(step_count), 64'(0));
        run_path(vecs[0]);

        // Asynchronous reset during the second record.
        grid = {16{C}};
        out_ready = 1'b1;
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            waits = 0;
            if (r > 0) @(negedge clk);
            while (!out_valid && waits < 12) begin
                @(negedge clk);
                waits++;
            end
        end
        check("mid x", 64'(out_x), 64'(2));
        check("mid steps", 64'(step_count), 64'(1));
        #1 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        reset = 1'b1;
        saw_busy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || dir_ren) saw_busy = 1'b1;
        end
        check("post_rst idle", 64'(saw_busy), 64'(0));
        run_path(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/traceback_walker.md
TRACEBACK_WALKER -- requirements
Module: traceback_walker

Interface
REQ-001 SHALL have parameter LENGTH, default 10: characters per string; the direction grid is LENGTH x LENGTH.
REQ-002 SHALL have parameter CORD_LENGTH, default 8: bits per coordinate.
REQ-003 SHALL have parameter ADDR_SIZE, default 9: bits of direction-memory address.
REQ-004 SHALL have parameters TOP_DIR 2'b00, LEFT_DIR 2'b01, CORNER_DIR 2'b10: direction codes; 2'b11 is illegal.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin a traceback at (x=LENGTH-1, y=LENGTH-1).
REQ-008 SHALL have port busy, output, 1 bit: traceback in progress.
REQ-009 SHALL have port dir_ren, output, 1 bit: direction-memory read strobe.
REQ-010 SHALL have port dir_addr, output, ADDR_SIZE bits: read address, y*LENGTH+x.
REQ-011 SHALL have port dir_rdata, input, 2 bits: direction code, valid the cycle after dir_ren.
REQ-012 SHALL have port out_valid, output, 1 bit: alignment record available.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the record.
REQ-014 SHALL have ports out_x and out_y, outputs, CORD_LENGTH bits each: cell coordinates of the record.
REQ-015 SHALL have port out_op, output, 2 bits: direction code of the record.
REQ-016 SHALL have port out_last, output, 1 bit: final record of the path.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-018 SHALL have port err, output, 1 bit: sticky illegal-direction flag.
REQ-019 SHALL have port step_count, output, CORD_LENGTH+1 bits: records accepted in the current or last run.

Function
REQ-020 SHALL implement states IDLE, FETCH, WAIT, EMIT, DONE, ERR.
REQ-021 SHALL, in IDLE with start=1 at an edge: load x=y=LENGTH-1, clear step_count and err, enter FETCH.
REQ-022 SHALL, in FETCH, drive dir_ren=1 and dir_addr=y*LENGTH+x for exactly one cycle, then enter WAIT.
REQ-023 SHALL, in WAIT, latch dir_rdata and enter ERR if the code is 2'b11, else EMIT.
REQ-024 SHALL, in EMIT, assert out_valid with out_x=x, out_y=y, out_op=latched code.
REQ-025 SHALL hold out_x, out_y, out_op and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL count a transfer only on a cycle with out_valid=1 and out_ready=1; out_ready with out_valid=0 has no effect.
REQ-027 SHALL update coordinates on transfer: TOP y-1; LEFT x-1; CORNER x-1 and y-1.
REQ-028 SHALL set out_last=1 when the move exits the grid: x==0 with LEFT or CORNER, or y==0 with TOP or CORNER.
REQ-029 SHALL, on transfer, increment step_count, then go to DONE if out_last=1, else to FETCH.
REQ-030 SHALL, in DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-031 SHALL, in ERR, set err=1, emit no record, not pulse done, and return to IDLE the next cycle.
REQ-032 SHALL assert busy=1 in FETCH, WAIT, EMIT and ERR, and busy=0 otherwise.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL have a minimum latency of 3 cycles from start sampled to first out_valid, and 3 cycles per subsequent step with out_ready held at 1.
REQ-035 SHALL never let coordinate arithmetic wrap below 0: the exiting move's update is discarded, and the path is at most 2*LENGTH-1 records.
REQ-036 SHALL hold err until the next accepted start or reset.

Reset
REQ-037 SHALL, while reset=0, immediately force state IDLE and busy, dir_ren, out_valid, out_last, done, err=0, step_count=0, dir_addr=0, out_x=0, out_y=0, out_op=0, including mid-traceback.
REQ-038 SHALL, after reset deasserts, start no traceback until a new start is sampled.

Verification (LENGTH=4)
REQ-039 SHALL cover: all cells CORNER, out_ready=1 -> records (3,3),(2,2),(1,1),(0,0); out_last on the 4th only; done pulse; step_count=4.
REQ-040 SHALL cover: row 3 all LEFT, start -> records (3,3),(2,3),(1,3),(0,3); out_last at x=0; reads at addresses 15,14,13,12.
REQ-041 SHALL cover: out_ready low for 5 cycles during the first EMIT -> record held unchanged; no extra read; step_count stays 0 until the transfer.
REQ-042 SHALL cover: dir_rdata=2'b11 at (3,3) -> no out_valid; err=1; busy falls; no done; next start clears err.
REQ-043 SHALL cover: reset pulsed low during the second EMIT -> all outputs at reset values asynchronously; a new start restarts at (3,3).
REQ-044 SHALL cover: start pulsed while busy -> ignored; path and step_count identical to an undisturbed run.
